// File: rtl/motoro3_commutator_ramp.sv
// Six-step BLDC commutation sequencer with a soft-start period ramp, direction select,
// a timed active brake and a saturating revolution counter. All state advances on the falling clock edge.
module motoro3_commutator_ramp #(
  parameter int CNT_W        = 25,
  parameter int START_PERIOD = 166_667,
  parameter int MIN_PERIOD   = 1_667,
  parameter int RAMP_W       = 16,
  parameter int BRAKE_CYC    = 100_000,
  parameter int ROUND_W      = 32
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic [CNT_W-1:0]   target_per,
  input  logic [RAMP_W-1:0]  ramp_step,
  output logic               aE,
  output logic               bE,
  output logic               cE,
  output logic               aH1_L0,
  output logic               bH1_L0,
  output logic               cH1_L0,
  output logic [2:0]         step,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   cur_per,
  output logic [CNT_W-1:0]   cnt,
  output logic               at_speed,
  output logic [ROUND_W-1:0] rounds
);

  // One extra bit so period +/- ramp arithmetic can never wrap.
  localparam int AW = ((CNT_W > RAMP_W) ? CNT_W : RAMP_W) + 1;

  localparam logic [CNT_W-1:0] START_P    = CNT_W'(START_PERIOD);
  localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_PERIOD - 1);
  localparam logic [CNT_W-1:0] MIN_P      = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] BRAKE_LOAD = CNT_W'(BRAKE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RAMP  = 2'd1,
    S_RUN   = 2'd2,
    S_BRAKE = 2'd3
  } state_e;

  state_e               state_q;
  state_e               run_d;
  logic [2:0]           step_q;
  logic [2:0]           step_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     per_q;
  logic [CNT_W-1:0]     per_d;
  logic [ROUND_W-1:0]   rounds_q;
  logic [ROUND_W-1:0]   rounds_d;
  logic                 start_q;

  logic                 start_up;
  logic                 running;
  logic                 brake_req;
  logic [CNT_W-1:0]     eff_tgt;
  logic [AW-1:0]        per_x;
  logic [AW-1:0]        tgt_x;
  logic [AW-1:0]        ramp_x;
  logic [2:0]           en_v;
  logic [2:0]           hi_v;

  assign start_up  = start & ~start_q;
  assign running   = (state_q == S_RAMP) || (state_q == S_RUN);
  assign brake_req = running && (stop || !start);
  assign eff_tgt   = (target_per < MIN_P) ? MIN_P : target_per;

  assign per_x  = AW'(per_q);
  assign tgt_x  = AW'(eff_tgt);
  assign ramp_x = AW'(ramp_step);

  // Move toward the target by ramp_step, landing exactly on it rather than overshooting.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    per_d = eff_tgt;
    if (ramp_step != '0) begin
      if ((per_x > tgt_x) && ((per_x - tgt_x) > ramp_x)) begin
        per_d = CNT_W'(per_x - ramp_x);
      end else if ((per_x < tgt_x) && ((tgt_x - per_x) > ramp_x)) begin
        per_d = CNT_W'(per_x + ramp_x);
      end
    end
  end

  always_comb begin
    if (dir) begin
      step_d = (step_q == 3'd6) ? 3'd1 : step_q + 3'd1;
    end else begin
      step_d = (step_q == 3'd1) ? 3'd6 : step_q - 3'd1;
    end
  end

  // Step 1 is only reachable from 6 (forward) or 2 (reverse), so landing on it is a wrap.
  assign rounds_d = ((step_d == 3'd1) && (rounds_q != '1)) ? rounds_q + ROUND_W'(1) : rounds_q;

  always_comb begin
    if (state_q == S_RUN) begin
      run_d = (eff_tgt != per_q) ? S_RAMP : S_RUN;
    end else begin
      run_d = (per_d == eff_tgt) ? S_RUN : S_RAMP;
    end
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= S_IDLE;
      step_q   <= 3'd0;
      cnt_q    <= '0;
      per_q    <= START_P;
      rounds_q <= '0;
      start_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      start_q <= start;
      unique case (state_q)
        S_IDLE: begin
          if (start_up && !stop) begin
            state_q  <= S_RAMP;
            step_q   <= 3'd1;
            per_q    <= START_P;
            cnt_q    <= START_LOAD;
            rounds_q <= '0;
          end
        end
        S_RAMP, S_RUN: begin
          if (brake_req) begin
            state_q <= S_BRAKE;
            step_q  <= 3'd0;
            cnt_q   <= BRAKE_LOAD;
          end else if (cnt_q == '0) begin
            state_q  <= run_d;
            step_q   <= step_d;
            rounds_q <= rounds_d;
            per_q    <= per_d;
            cnt_q    <= per_d - 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_BRAKE: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Phase decode: bit order is {a, b, c}.
  always_comb begin
    en_v = 3'b000;
    hi_v = 3'b000;
    if (state_q == S_BRAKE) begin
      en_v = 3'b111;
    end else if (running) begin
      unique case (step_q)
        3'd1:    begin en_v = 3'b101; hi_v = 3'b100; end
        3'd2:    begin en_v = 3'b011; hi_v = 3'b010; end
        3'd3:    begin en_v = 3'b110; hi_v = 3'b010; end
        3'd4:    begin en_v = 3'b101; hi_v = 3'b001; end
        3'd5:    begin en_v = 3'b011; hi_v = 3'b001; end
        3'd6:    begin en_v = 3'b110; hi_v = 3'b100; end
        default: begin en_v = 3'b000; hi_v = 3'b000; end
      endcase
    end
  end

  assign {aE, bE, cE}             = en_v;
  assign {aH1_L0, bH1_L0, cH1_L0} = hi_v;
  assign step                     = step_q;
  assign state                    = state_q;
  assign cur_per                  = per_q;
  assign cnt                      = cnt_q;
  assign at_speed                 = (state_q == S_RUN);
  assign rounds                   = rounds_q;

endmodule

// File: tb/tb_motoro3_commutator_ramp.sv
// Bench for motoro3_commutator_ramp: a ramp vector table, directed corner sequences, and
// randomized stimulus checked every cycle against an arithmetic reference model.
module tb_motoro3_commutator_ramp;

  localparam int CW  = 8;
  localparam int SP  = 20;
  localparam int MP  = 4;
  localparam int RW  = 8;
  localparam int BC  = 8;
  localparam int ROW = 3;
  localparam int RMAX = (1 << ROW) - 1;

  logic          clk = 1'b0;
  logic          nRst;
  logic          start;
  logic          stop;
  logic          dir;
  logic [CW-1:0] target_per;
  logic [RW-1:0] ramp_step;
  logic          aE, bE, cE, aH1_L0, bH1_L0, cH1_L0;
  logic [2:0]    step;
  logic [1:0]    state;
  logic [CW-1:0] cur_per;
  logic [CW-1:0] cnt;
  logic          at_speed;
  logic [ROW-1:0] rounds;

  int total = 0;
  int bad   = 0;

  motoro3_commutator_ramp #(
    .CNT_W(CW), .START_PERIOD(SP), .MIN_PERIOD(MP),
    .RAMP_W(RW), .BRAKE_CYC(BC), .ROUND_W(ROW)
  ) dut (
    .clk(clk), .nRst(nRst), .start(start), .stop(stop), .dir(dir),
    .target_per(target_per), .ramp_step(ramp_step),
    .aE(aE), .bE(bE), .cE(cE), .aH1_L0(aH1_L0), .bH1_L0(bH1_L0), .cH1_L0(cH1_L0),
    .step(step), .state(state), .cur_per(cur_per), .cnt(cnt),
    .at_speed(at_speed), .rounds(rounds)
  );

  always #50 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: states 0..3, step 0..6, counters as plain integers.
  typedef struct {
    int st;
    int stp;
    int cnt;
    int per;
    int rounds;
    bit start_d;
  } model_t;

  model_t m;

  function automatic model_t mnext(model_t c, bit st_i, bit sp_i, bit d_i, int tgt_i, int rs_i);
    model_t n;
    int eff;
    n = c;
    n.start_d = st_i;
    eff = (tgt_i < MP) ? MP : tgt_i;
    case (c.st)
      0: if (st_i && !c.start_d && !sp_i) begin
           n.st = 1; n.stp = 1; n.per = SP; n.cnt = SP - 1; n.rounds = 0;
         end
      1, 2: begin
        if (sp_i || !st_i) begin
          n.st = 3; n.stp = 0; n.cnt = BC - 1;
        end else if (c.cnt == 0) begin
          n.stp = d_i ? (c.stp % 6) + 1 : ((c.stp + 4) % 6) + 1;
          if (n.stp == 1 && n.rounds < RMAX) n.rounds = n.rounds + 1;
          if (rs_i == 0)       n.per = eff;
          else if (c.per > eff) n.per = (c.per - rs_i < eff) ? eff : c.per - rs_i;
          else                  n.per = (c.per + rs_i > eff) ? eff : c.per + rs_i;
          n.cnt = n.per - 1;
          if (c.st == 2) n.st = (eff != c.per) ? 1 : 2;
          else           n.st = (n.per == eff) ? 2 : 1;
        end else begin
          n.cnt = c.cnt - 1;
        end
      end
      default: if (c.cnt == 0) n.st = 0; else n.cnt = c.cnt - 1;
    endcase
    return n;
  endfunction

  function automatic logic [5:0] phase_of(int st, int stp);
    if (st == 3) return 6'b111_000;
    if (st == 0) return 6'b000_000;
    case (stp)
      1: return 6'b101_100;
      2: return 6'b011_010;
      3: return 6'b110_010;
      4: return 6'b101_001;
      5: return 6'b011_001;
      6: return 6'b110_100;
      default: return 6'b000_000;
    endcase
  endfunction

  function automatic logic [30:0] exp_vec(model_t c);
    return {2'(c.st), 3'(c.stp), 8'(c.per), 8'(c.cnt), 3'(c.rounds),
            phase_of(c.st, c.stp), (c.st == 2)};
  endfunction

  logic [30:0] dut_vec;
  assign dut_vec = {state, step, cur_per, cnt, rounds,
                    aE, bE, cE, aH1_L0, bH1_L0, cH1_L0, at_speed};

  always @(negedge clk or negedge nRst) begin
    if (!nRst) m <= '{st: 0, stp: 0, cnt: 0, per: SP, rounds: 0, start_d: 1'b0};
    else       m <= mnext(m, start, stop, dir, int'(target_per), int'(ramp_step));
  end

  always @(posedge clk) begin
    if (nRst === 1'b1) check("model", 64'(dut_vec), 64'(exp_vec(m)));
  end

  task automatic wait_step(input string name, input int want);
    int n;
    n = 0;
    while (step !== 3'(want) && n < 200) begin
      @(posedge clk);
      n++;
    end
    check(name, step, want);
  endtask

  task automatic wait_change(input string name, input int want);
    logic [2:0] prev;
    int n;
    prev = step;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (step == prev && n < 100);
    check(name, step, want);
  endtask

  typedef struct {
    int dir;
    int tgt;
    int rs;
    int stp;
    int per;
    int st;
    int en;
    int hi;
    int rnd;
  } vec_t;

  initial begin
    #(100 * 50000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec [7];
    int n;
    vec[0] = '{1, 10, 5, 1, 20, 1, 3'b101, 3'b100, 0};
    vec[1] = '{1, 10, 5, 2, 15, 1, 3'b011, 3'b010, 0};
    vec[2] = '{1, 10, 5, 3, 10, 2, 3'b110, 3'b010, 0};
    vec[3] = '{1, 10, 5, 4, 10, 2, 3'b101, 3'b001, 0};
    vec[4] = '{1, 10, 5, 5, 10, 2, 3'b011, 3'b001, 0};
    vec[5] = '{1, 10, 5, 6, 10, 2, 3'b110, 3'b100, 0};
    vec[6] = '{1, 10, 5, 1, 10, 2, 3'b101, 3'b100, 1};

    nRst = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b1;
    target_per = 8'd10; ramp_step = 8'd5;
    repeat (3) @(posedge clk);
    nRst = 1'b1;
    @(posedge clk);
    check("idle_state", state, 0);
    check("idle_per", cur_per, SP);

    // Ramp 20 -> 15 -> 10 and the full forward commutation table.
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      dir = vec[i].dir[0]; target_per = 8'(vec[i].tgt); ramp_step = 8'(vec[i].rs);
      check($sformatf("ramp%0d_step", i), step, vec[i].stp);
      check($sformatf("ramp%0d_per", i), cur_per, vec[i].per);
      check($sformatf("ramp%0d_cnt", i), cnt, vec[i].per - 1);
      check($sformatf("ramp%0d_state", i), {state, at_speed}, {2'(vec[i].st), vec[i].st == 2});
      check($sformatf("ramp%0d_phase", i), {aE, bE, cE, aH1_L0, bH1_L0, cH1_L0},
            {3'(vec[i].en), 3'(vec[i].hi)});
      check($sformatf("ramp%0d_rounds", i), rounds, vec[i].rnd);
      repeat (vec[i].per) @(posedge clk);
    end

    // Asynchronous reset in the middle of a step.
    #10 nRst = 1'b0;
    start = 1'b0;
    #5;
    check("rst_phase", {aE, bE, cE, aH1_L0, bH1_L0, cH1_L0, at_speed}, 0);
    check("rst_step_state", {step, state}, 0);
    check("rst_regs", {cur_per, cnt, rounds}, {8'(SP), 8'd0, 3'd0});
    @(posedge clk);
    nRst = 1'b1;
    @(posedge clk);

    // Clamp to MIN_PERIOD with ramp_step = 0, then first revolution.
    target_per = 8'd2; ramp_step = 8'd0; dir = 1'b1;
    start = 1'b1;
    @(posedge clk);
    check("clamp_first", {step, cur_per}, {3'd1, 8'(SP)});
    wait_change("clamp_step2", 2);
    check("clamp_per", cur_per, MP);
    check("clamp_run", state, 2);
    wait_step("rev_to6", 6);
    wait_step("rev_to1", 1);
    check("rounds_first", rounds, 1);

    // Reverse direction requested in the middle of step 3.
    wait_step("rev_pre3", 3);
    @(posedge clk);
    dir = 1'b0;
    wait_change("rev_2", 2);
    wait_change("rev_1", 1);
    check("rev_rounds", rounds, 2);
    wait_change("rev_6", 6);
    wait_change("rev_5", 5);

    // Stop pulse coinciding with the 2 -> 1 step end.
    wait_step("brk_pre2", 2);
    n = 0;
    while (cnt !== '0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    check("brk_align", cnt, 0);
    stop = 1'b1;
    @(posedge clk);
    stop = 1'b0;
    check("brk_state", {state, step}, {2'd3, 3'd0});
    check("brk_phase", {aE, bE, cE, aH1_L0, bH1_L0, cH1_L0}, 6'b111_000);
    check("brk_cnt", cnt, BC - 1);
    check("brk_rounds", rounds, 2);
    for (int i = 1; i < BC; i++) begin
      @(posedge clk);
      check($sformatf("brk_hold%0d", i), state, 3);
    end
    @(posedge clk);
    check("brk_idle", {state, rounds}, {2'd0, 3'd2});

    // start held high through BRAKE, stop blocking launch, then a clean relaunch.
    repeat (5) @(posedge clk);
    check("guard_held", state, 0);
    stop = 1'b1; start = 1'b0;
    @(posedge clk);
    start = 1'b1;
    repeat (2) @(posedge clk);
    check("guard_stop", state, 0);
    stop = 1'b0;
    repeat (3) @(posedge clk);
    check("guard_noedge", state, 0);
    start = 1'b0;
    @(posedge clk);
    start = 1'b1;
    @(posedge clk);
    check("relaunch", {state, step, cur_per, rounds}, {2'd1, 3'd1, 8'(SP), 3'd0});

    // Long run: the revolution counter must stick at all-ones.
    repeat (450) @(posedge clk);
    check("rounds_sat", rounds, RMAX);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 80; it++) begin
      dir = 1'($urandom_range(0, 1));
      target_per = 8'($urandom_range(0, 40));
      ramp_step = 8'($urandom_range(0, 12));
      case ($urandom_range(0, 7))
        0: stop = 1'b1;
        1: start = 1'b0;
        2: begin start = 1'b0; @(posedge clk); start = 1'b1; end
        default: ;
      endcase
      @(posedge clk);
      stop = 1'b0;
      start = 1'b1;
      repeat ($urandom_range(1, 60)) @(posedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
